led_fader: RTL and testbench



---
 rtl/led_pkg.sv | 16 +
 rtl/led_pwm.sv | 43 ++++
 rtl/led_fader.sv | 91 +++++++++
 tb/tb_led_fader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED brightness blocks: ramp state encoding and
// full-scale level derivation.
package led_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_e;

    function automatic int lvl_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM generator: free-running period counter, duty shadow loaded at the period
// boundary, and a registered compare output.
module led_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                enable_i,
    input  logic [PWM_BITS-1:0] level_i,
    output logic                led_out_o
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(lvl_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    always_comb begin
        cnt_d  = (cnt_q == LVL_MAX) ? '0 : cnt_q + CNT_ONE;
        // duty only moves between periods so a period never mixes two levels
        duty_d = (cnt_q == LVL_MAX) ? level_i : duty_q;
        led_d  = enable_i & ((duty_q == LVL_MAX) | (cnt_q < duty_q));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led_out_o = led_q;

endmodule

// File: rtl/led_fader.sv
// LED fader: turns an on/off request into a linear brightness ramp and hands
// the current level to the PWM stage.
module led_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS         = 8,
    parameter int RAMP_STEP_CYCLES = 4096
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_on_i,
    input  logic                enable_i,
    output logic                led_out_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic                busy_o
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(lvl_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);
    localparam int                  PS_W    = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [PS_W-1:0]     PS_ONE  = PS_W'(1);

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic                busy_q, busy_d;
    logic                tick;

    assign tick = enable_i & busy_q & (presc_q == PS_LAST);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        presc_d = presc_q;
        if (enable_i) begin
            if (busy_q) presc_d = tick ? '0 : presc_q + PS_ONE;
            // reversal is checked first so it always wins over a same-cycle tick;
            // the level-at-limit arms keep LEVEL from ever wrapping
            unique case (state_q)
                ST_OFF: if (req_on_i) state_d = ST_UP;
                ST_UP: begin
                    if (!req_on_i) state_d = ST_DOWN;
                    else if (level_q == LVL_MAX) state_d = ST_ON;
                    else if (tick) begin
                        level_d = level_q + LVL_ONE;
                        if (level_q + LVL_ONE == LVL_MAX) state_d = ST_ON;
                    end
                end
                ST_ON: if (!req_on_i) state_d = ST_DOWN;
                ST_DOWN: begin
                    if (req_on_i) state_d = ST_UP;
                    else if (level_q == '0) state_d = ST_OFF;
                    else if (tick) begin
                        level_d = level_q - LVL_ONE;
                        if (level_q == LVL_ONE) state_d = ST_OFF;
                    end
                end
                default: state_d = ST_OFF;
            endcase
            if (state_d != state_q) presc_d = '0;
        end
        busy_d = (state_d == ST_UP) | (state_d == ST_DOWN);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_OFF;
            level_q <= '0;
            presc_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            presc_q <= presc_d;
            busy_q  <= busy_d;
        end
    end

    led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .enable_i  (enable_i),
        .level_i   (level_q),
        .led_out_o (led_out_o)
    );

    assign level_o = level_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with a 4-bit PWM and 4-clock ramp step.
module tb_led_fader;

    localparam int PB = 4;
    localparam int RS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_on = 1'b0;
    logic          enable = 1'b1;
    logic          led_out;
    logic          busy;
    logic [PB-1:0] level;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    led_fader #(.PWM_BITS(PB), .RAMP_STEP_CYCLES(RS)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_on_i  (req_on),
        .enable_i  (enable),
        .led_out_o (led_out),
        .level_o   (level),
        .busy_o    (busy)
    );

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_on = 1'b0;
        enable = 1'b1;
        rst_n  = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        int hi;
        int lit;

        #1;
        chk("rst_led", led_out, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("idle_busy", busy, 0);

        // ramp up: UP on the first edge, one level per 4 clocks, ON at 60
        req_on = 1'b1;
        step(1);
        chk("up_busy", busy, 1);
        chk("up_lvl0", level, 0);
        step(3);
        chk("up_lvl0_hold", level, 0);
        step(1);
        chk("up_lvl1", level, 1);
        step(55);
        chk("up_lvl14", level, 14);
        chk("up_busy14", busy, 1);
        step(1);
        chk("up_lvl15", level, 15);
        chk("on_busy", busy, 0);

        // full level: output constantly high once the duty shadow reloads
        step(17);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            hi += int'(led_out);
        end
        chk("duty15_high", hi, 16);
        chk("on_level", level, 15);

        // reversal at level 9
        do_reset();
        req_on = 1'b1;
        step(37);
        chk("rev_lvl9", level, 9);
        req_on = 1'b0;
        step(1);
        chk("rev_busy", busy, 1);
        chk("rev_lvl9_e0", level, 9);
        step(3);
        chk("rev_lvl9_e3", level, 9);
        step(1);
        chk("rev_lvl8", level, 8);
        step(31);
        chk("rev_lvl1", level, 1);
        chk("rev_busy35", busy, 1);
        step(1);
        chk("rev_lvl0", level, 0);
        chk("rev_off", busy, 0);

        // short pulse: UP then DOWN then OFF, never lit
        do_reset();
        lit = 0;
        req_on = 1'b1;
        step(1);
        chk("sp_busy", busy, 1);
        lit |= int'(led_out);
        step(2);
        lit |= int'(led_out);
        req_on = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            lit |= int'(led_out);
        end
        chk("sp_lit", lit, 0);
        chk("sp_level", level, 0);
        chk("sp_off", busy, 0);

        // enable freeze at level 6
        do_reset();
        req_on = 1'b1;
        step(25);
        chk("en_lvl6", level, 6);
        enable = 1'b0;
        lit = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            lit |= int'(led_out);
        end
        chk("en_led_off", lit, 0);
        chk("en_lvl_held", level, 6);
        enable = 1'b1;
        step(3);
        chk("en_lvl6_resume", level, 6);
        step(1);
        chk("en_lvl7", level, 7);

        // hold level 5 by reversing every clock; 5 of 16 clocks high
        do_reset();
        req_on = 1'b1;
        step(21);
        chk("d5_lvl5", level, 5);
        hi = 0;
        for (int i = 0; i < 48; i++) begin
            req_on = ~req_on;
            step(1);
            if (i >= 32) hi += int'(led_out);
        end
        chk("duty5_high", hi, 5);
        chk("d5_lvl_held", level, 5);

        // async reset mid-ramp at level 7
        do_reset();
        req_on = 1'b1;
        step(29);
        chk("mr_lvl7", level, 7);
        req_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_led", led_out, 0);
        chk("mr_level", level, 0);
        chk("mr_busy", busy, 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("mr_off_busy", busy, 0);
        chk("mr_off_level", level, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
